// File: rtl/ahb_mem_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_bus_pkg : AHB-Lite encodings and MEM sequencer state type.
// Define MEM_SEQ_ERR_EN to add the ERR2 state for bus-error handling.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mips_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

`ifdef MEM_SEQ_ERR_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR2 = 3'd3,
    ST_DONE = 3'd4
  } mem_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd4
  } mem_state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/ahb_mem_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_mem_sequencer_if : 32-bit AHB-Lite master/slave signal bundle.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ahb_mem_sequencer_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hready, hresp, hrdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_mem_sequencer_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lane_align : store lane replication and load lane extraction/extension
// (little-endian byte lanes). Purely combinational.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_lane_align
  import mips_bus_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      HSIZE_BYTE: begin
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      end
      HSIZE_HALF: begin
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahb_mem_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_mem_sequencer : runs the MEM-stage load/store as one AHB-Lite transfer
// and stalls the pipeline until it completes. Macro: MEM_SEQ_ERR_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ahb_mem_sequencer
  import mips_bus_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [2:0]          req_size,
  input  logic                req_unsigned,
  ahb_mem_sequencer_if.master bus,
  output logic [31:0]         rdata_out,
  output logic                rdata_valid,
  output logic                stall_out,
  output logic                misalign_out,
  output logic                err_out
);

  mem_state_e  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        misalign_q, misalign_d;
`ifdef MEM_SEQ_ERR_EN
  logic        err_q, err_d;
`endif

  logic        w_idle;
  logic        w_misalign;
  logic [31:0] w_wdata_lane;
  logic [31:0] w_rdata_ext;

  assign w_idle     = (state_q == ST_IDLE);
  assign w_misalign = ((req_size == HSIZE_HALF) &&  req_addr[0]) ||
                      ((req_size == HSIZE_WORD) && (req_addr[1:0] != 2'b00));

  // Lane unit sees the live request while idle (store laning) and the
  // latched access afterwards (load extraction).
  mem_lane_align u_lane_align (
    .size        (w_idle ? req_size       : hsize_q),
    .addr_lo     (w_idle ? req_addr[1:0]  : haddr_q[1:0]),
    .is_unsigned (w_idle ? req_unsigned   : unsigned_q),
    .wdata       (req_wdata),
    .rdata       (bus.hrdata),
    .wdata_lane  (w_wdata_lane),
    .rdata_ext   (w_rdata_ext)
  );

  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hwdata_d      = hwdata_q;
    unsigned_d    = unsigned_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
`ifdef MEM_SEQ_ERR_EN
    err_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_misalign) begin
            state_d       = ST_DONE;
            misalign_d    = 1'b1;
            rdata_d       = 32'd0;
            rdata_valid_d = 1'b1;
          end else begin
            state_d    = ST_ADDR;
            haddr_d    = req_addr;
            hsize_d    = req_size;
            hwrite_d   = req_write;
            unsigned_d = req_unsigned;
            hwdata_d   = w_wdata_lane;
            htrans_d   = HTRANS_NONSEQ;
          end
        end
      end
      ST_ADDR: begin
        if (bus.hready) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_DATA: begin
`ifdef MEM_SEQ_ERR_EN
        if (bus.hready) begin
          state_d       = ST_DONE;
          rdata_valid_d = 1'b1;
          if (bus.hresp) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (!hwrite_q) begin
            rdata_d = w_rdata_ext;
          end
        end else if (bus.hresp) begin
          state_d = ST_ERR2;
        end
`else
        if (bus.hready) begin
          state_d       = ST_DONE;
          rdata_valid_d = 1'b1;
          if (!hwrite_q) rdata_d = w_rdata_ext;
        end
`endif
      end
`ifdef MEM_SEQ_ERR_EN
      ST_ERR2: begin
        if (bus.hready) begin
          state_d       = ST_DONE;
          rdata_valid_d = 1'b1;
          err_d         = 1'b1;
          rdata_d       = 32'd0;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      haddr_q       <= 32'd0;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      hsize_q       <= 3'd0;
      hwdata_q      <= 32'd0;
      unsigned_q    <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
`ifdef MEM_SEQ_ERR_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hwdata_q      <= hwdata_d;
      unsigned_q    <= unsigned_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
`ifdef MEM_SEQ_ERR_EN
      err_q         <= err_d;
`endif
    end
  end

  assign bus.haddr    = haddr_q;
  assign bus.htrans   = htrans_q;
  assign bus.hwrite   = hwrite_q;
  assign bus.hsize    = hsize_q;
  assign bus.hwdata   = hwdata_q;
  assign rdata_out    = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign misalign_out = misalign_q;
  // Gated by rst_n so the stall drops immediately when reset aborts a transfer.
  assign stall_out    = rst_n & req_valid & (state_q != ST_DONE);

`ifdef MEM_SEQ_ERR_EN
  assign err_out = err_q;
`else
  logic unused_hresp;
  assign unused_hresp = bus.hresp;
  assign err_out      = 1'b0;
`endif

endmodule
`default_nettype wire
